// File: rtl/sram_phase_sequencer_if.sv
// Shared SRAM port bundle: start/finish handshakes of the three requesters,
// their bus requests, and the muxed SRAM bus plus sequencer status.
interface sram_phase_sequencer_if;
  logic        go;

  logic [17:0] uart_address;
  logic [15:0] uart_write_data;
  logic        uart_write_en_n;
  logic        uart_done;

  logic [17:0] m2_address;
  logic [15:0] m2_write_data;
  logic        m2_write_en_n;
  logic        m2_finish;

  logic [17:0] m1_address;
  logic [15:0] m1_write_data;
  logic        m1_write_en_n;
  logic        m1_finish;

  logic        uart_enable;
  logic        m2_start;
  logic        m1_start;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  phase;

  // Requester / controlling side.
  modport master (
    output go,
    output uart_address, uart_write_data, uart_write_en_n, uart_done,
    output m2_address, m2_write_data, m2_write_en_n, m2_finish,
    output m1_address, m1_write_data, m1_write_en_n, m1_finish,
    input  uart_enable, m2_start, m1_start,
    input  SRAM_address, SRAM_write_data, SRAM_we_n,
    input  busy, done, error, phase
  );

  // Sequencer side.
  modport slave (
    input  go,
    input  uart_address, uart_write_data, uart_write_en_n, uart_done,
    input  m2_address, m2_write_data, m2_write_en_n, m2_finish,
    input  m1_address, m1_write_data, m1_write_en_n, m1_finish,
    output uart_enable, m2_start, m1_start,
    output SRAM_address, SRAM_write_data, SRAM_we_n,
    output busy, done, error, phase
  );
endinterface

// File: rtl/sram_phase_sequencer.sv
// Schedules the single external SRAM port across the UART loader, the
// milestone 2 IDCT block and the milestone 1 upsample/CSC block. Phases run
// LOAD -> M2 -> M1 with an ownerless handover gap between them; a per-phase
// watchdog aborts to ERROR if a requester never finishes.
module sram_phase_sequencer #(
  parameter int unsigned HANDOVER_GAP   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4194303,
  parameter bit          SKIP_LOAD      = 1'b0
) (
  input logic                   CLOCK_50_I,
  input logic                   Resetn,
  sram_phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP1  = 3'd2,
    S_M2    = 3'd3,
    S_GAP2  = 3'd4,
    S_M1    = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  localparam logic [3:0]  GAP_LAST  = 4'(HANDOVER_GAP - 1);
  localparam logic [21:0] WD_LAST   = 22'(TIMEOUT_CYCLES - 1);
  localparam state_t      GO_TARGET = SKIP_LOAD ? S_M2 : S_LOAD;

  state_t      state;
  state_t      state_next;
  logic [3:0]  gap_cnt;
  logic [21:0] wd_cnt;
  logic        first_q;

  logic        entering;
  logic        in_gap;
  logic        in_phase;
  logic        gap_last;
  logic        wd_expired;

  // Status decode of the registered state and counters.
  always_comb begin
    in_gap     = (state == S_GAP1) || (state == S_GAP2);
    in_phase   = (state == S_LOAD) || (state == S_M2) || (state == S_M1);
    gap_last   = (gap_cnt == GAP_LAST);
    wd_expired = (wd_cnt == WD_LAST);
  end

  // Next-state decision; finish is checked before the watchdog so it wins a tie.
  // first_q masks M2/M1 finish in their start cycle so a stale level is ignored.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.go) state_next = GO_TARGET;
      end
      S_LOAD: begin
        if (bus.uart_done)  state_next = S_GAP1;
        else if (wd_expired) state_next = S_ERROR;
      end
      S_GAP1: begin
        if (gap_last) state_next = S_M2;
      end
      S_M2: begin
        if (!first_q && bus.m2_finish) state_next = S_GAP2;
        else if (wd_expired)           state_next = S_ERROR;
      end
      S_GAP2: begin
        if (gap_last) state_next = S_M1;
      end
      S_M1: begin
        if (!first_q && bus.m1_finish) state_next = S_DONE;
        else if (wd_expired)           state_next = S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
    entering = (state_next != state);
  end

  // State register plus entry flag, gap counter and watchdog, all restarted on entry.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      first_q <= 1'b0;
      gap_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_next;
      first_q <= entering;
      if (entering || !in_gap) gap_cnt <= '0;
      else                     gap_cnt <= gap_cnt + 4'd1;
      if (entering || !in_phase) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + 22'd1;
    end
  end

  // Handshake and status outputs, decoded from the registered state only.
  always_comb begin
    bus.uart_enable = (state == S_LOAD);
    bus.m2_start    = (state == S_M2) && first_q;
    bus.m1_start    = (state == S_M1) && first_q;
    bus.busy        = in_phase || in_gap;
    bus.done        = (state == S_DONE);
    bus.error       = (state == S_ERROR);
    bus.phase       = state;
  end

  // SRAM bus mux: only the current phase owner reaches the port.
  always_comb begin
    bus.SRAM_address    = '0;
    bus.SRAM_write_data = '0;
    bus.SRAM_we_n       = 1'b1;
    case (state)
      S_LOAD: begin
        bus.SRAM_address    = bus.uart_address;
        bus.SRAM_write_data = bus.uart_write_data;
        bus.SRAM_we_n       = bus.uart_write_en_n;
      end
      S_M2: begin
        bus.SRAM_address    = bus.m2_address;
        bus.SRAM_write_data = bus.m2_write_data;
        bus.SRAM_we_n       = bus.m2_write_en_n;
      end
      S_M1: begin
        bus.SRAM_address    = bus.m1_address;
        bus.SRAM_write_data = bus.m1_write_data;
        bus.SRAM_we_n       = bus.m1_write_en_n;
      end
      default: begin
        bus.SRAM_address    = '0;
        bus.SRAM_write_data = '0;
        bus.SRAM_we_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Bench for sram_phase_sequencer: a queue of expected phase segments
// (phase, length) drives both the requester stimulus and the per-cycle checks.
module tb_sram_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  sram_phase_sequencer_if bus();
  sram_phase_sequencer_if bus_s();

  sram_phase_sequencer #(
    .HANDOVER_GAP   (2),
    .TIMEOUT_CYCLES (50),
    .SKIP_LOAD      (1'b0)
  ) dut (
    .CLOCK_50_I (clk),
    .Resetn     (rst_n),
    .bus        (bus)
  );

  sram_phase_sequencer #(
    .HANDOVER_GAP   (2),
    .TIMEOUT_CYCLES (50),
    .SKIP_LOAD      (1'b1)
  ) dut_skip (
    .CLOCK_50_I (clk),
    .Resetn     (rst_n),
    .bus        (bus_s)
  );

  assign bus_s.go              = bus.go;
  assign bus_s.uart_address    = bus.uart_address;
  assign bus_s.uart_write_data = bus.uart_write_data;
  assign bus_s.uart_write_en_n = bus.uart_write_en_n;
  assign bus_s.uart_done       = bus.uart_done;
  assign bus_s.m2_address      = bus.m2_address;
  assign bus_s.m2_write_data   = bus.m2_write_data;
  assign bus_s.m2_write_en_n   = bus.m2_write_en_n;
  assign bus_s.m2_finish       = bus.m2_finish;
  assign bus_s.m1_address      = bus.m1_address;
  assign bus_s.m1_write_data   = bus.m1_write_data;
  assign bus_s.m1_write_en_n   = bus.m1_write_en_n;
  assign bus_s.m1_finish       = bus.m1_finish;

  typedef struct {
    logic [2:0] ph;
    int         dur;
  } seg_t;

  seg_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [43:0] IDLE_OUT = {6'b0, 3'd0, 18'd0, 16'd0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] all_out_main();
    return {bus.uart_enable, bus.m2_start, bus.m1_start, bus.busy, bus.done, bus.error,
            bus.phase, bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n};
  endfunction

  // Random requester traffic; a fixed pattern in M2 position 5.
  task automatic drive_bus(input logic [2:0] ep, input int pos);
    bus.uart_address    = 18'($urandom);
    bus.uart_write_data = 16'($urandom);
    bus.uart_write_en_n = ($urandom_range(0, 3) == 0);
    bus.m2_address      = 18'($urandom);
    bus.m2_write_data   = 16'($urandom);
    bus.m2_write_en_n   = ($urandom_range(0, 3) == 0);
    bus.m1_address      = 18'($urandom);
    bus.m1_write_data   = 16'($urandom);
    bus.m1_write_en_n   = ($urandom_range(0, 3) == 0);
    if (ep == 3'd3 && pos == 5) begin
      bus.m2_address      = 18'h01234;
      bus.m2_write_data   = 16'hBEEF;
      bus.m2_write_en_n   = 1'b0;
      bus.m1_write_en_n   = 1'b0;
      bus.uart_write_en_n = 1'b0;
    end
  endtask

  // Issues go, then follows the queued segments cycle by cycle. Each
  // requester's finish is pulsed in the last expected cycle of its phase when
  // enabled in fin_en, or held high for the whole run when set in hold.
  task automatic run_seq(input string name, input logic [2:0] fin_en, input logic [2:0] hold,
                         input bit go_busy, input logic [2:0] end_ph, input int tail);
    seg_t        cur;
    int          left;
    int          pos;
    int          ncyc;
    logic [2:0]  ep;
    logic [5:0]  exp_flags;
    logic [5:0]  got_flags;
    logic [34:0] exp_bus;
    logic [34:0] got_bus;
    ncyc = tail;
    foreach (exp_q[i]) ncyc += exp_q[i].dur;
    bus.uart_done = hold[0];
    bus.m2_finish = hold[1];
    bus.m1_finish = hold[2];
    drive_bus(3'd0, 0);
    bus.go = 1'b1;
    left = 0;
    pos  = 0;
    ep   = end_ph;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (left == 0) begin
        if (exp_q.size() > 0) begin
          cur  = exp_q.pop_front();
          ep   = cur.ph;
          left = cur.dur;
        end else begin
          ep   = end_ph;
          left = 1 << 30;
        end
        pos = 0;
      end

      total++;
      if (bus.phase !== ep)
        $display("FAIL %s phase cyc %0d: got %0d expected %0d", name, c, bus.phase, ep);
      else
        passed++;

      exp_flags = {ep == 3'd1, (ep == 3'd3) && (pos == 0), (ep == 3'd5) && (pos == 0),
                   (ep >= 3'd1) && (ep <= 3'd5), ep == 3'd6, ep == 3'd7};
      got_flags = {bus.uart_enable, bus.m2_start, bus.m1_start, bus.busy, bus.done, bus.error};
      total++;
      if (got_flags !== exp_flags)
        $display("FAIL %s flags cyc %0d: got %b expected %b (uen,m2s,m1s,busy,done,err)",
                 name, c, got_flags, exp_flags);
      else
        passed++;

      case (ep)
        3'd1:    exp_bus = {bus.uart_address, bus.uart_write_data, bus.uart_write_en_n};
        3'd3:    exp_bus = {bus.m2_address, bus.m2_write_data, bus.m2_write_en_n};
        3'd5:    exp_bus = {bus.m1_address, bus.m1_write_data, bus.m1_write_en_n};
        default: exp_bus = {18'd0, 16'd0, 1'b1};
      endcase
      got_bus = {bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n};
      total++;
      if (got_bus !== exp_bus)
        $display("FAIL %s sram cyc %0d phase %0d: got %h expected %h", name, c, ep, got_bus, exp_bus);
      else
        passed++;

      pos++;
      left--;
      bus.go        = go_busy && (ep == 3'd5) && (pos % 3 == 1);
      bus.uart_done = hold[0] | (fin_en[0] && ep == 3'd1 && left == 0);
      bus.m2_finish = hold[1] | (fin_en[1] && ep == 3'd3 && left == 0);
      bus.m1_finish = hold[2] | (fin_en[2] && ep == 3'd5 && left == 0);
      drive_bus(ep, pos);
    end
    bus.go        = 1'b0;
    bus.uart_done = 1'b0;
    bus.m2_finish = 1'b0;
    bus.m1_finish = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [43:0] got;
    bus.go = 1'b0;
    bus.uart_done = 1'b0; bus.m2_finish = 1'b0; bus.m1_finish = 1'b0;
    drive_bus(3'd0, 0);
    bus.uart_write_en_n = 1'b0; bus.m2_write_en_n = 1'b0; bus.m1_write_en_n = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    got = all_out_main();
    total++;
    if (got !== IDLE_OUT) $display("FAIL reset_outputs: got %h expected %h", got, IDLE_OUT);
    else passed++;
    rst_n = 1'b1;
    repeat (3) tick();
    got = all_out_main();
    total++;
    if (got !== IDLE_OUT) $display("FAIL reset_release_idle: got %h expected %h", got, IDLE_OUT);
    else passed++;
  endtask

  task automatic test_skip_load();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    total++;
    if ({bus_s.phase, bus_s.m2_start, bus_s.busy} !== {3'd3, 1'b1, 1'b1})
      $display("FAIL skip_load_m2: got phase %0d start %b busy %b expected 3 1 1",
               bus_s.phase, bus_s.m2_start, bus_s.busy);
    else passed++;
    total++;
    if (bus.phase !== 3'd1) $display("FAIL noskip_load: got phase %0d expected 1", bus.phase);
    else passed++;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({bus.phase, bus_s.phase} !== 6'd0)
      $display("FAIL skip_reset: got %0d/%0d expected 0/0", bus.phase, bus_s.phase);
    else passed++;
  endtask

  task automatic test_full_run();
    exp_q.push_back('{3'd1, 10});
    exp_q.push_back('{3'd2, 2});
    exp_q.push_back('{3'd3, 20});
    exp_q.push_back('{3'd4, 2});
    exp_q.push_back('{3'd5, 30});
    run_seq("full", 3'b111, 3'b000, 1'b1, 3'd6, 5);
  endtask

  task automatic test_stale_finish();
    exp_q.push_back('{3'd1, 1});
    exp_q.push_back('{3'd2, 2});
    exp_q.push_back('{3'd3, 2});
    exp_q.push_back('{3'd4, 2});
    exp_q.push_back('{3'd5, 2});
    run_seq("stale", 3'b000, 3'b111, 1'b0, 3'd6, 3);
  endtask

  task automatic test_timeout();
    exp_q.push_back('{3'd1, 4});
    exp_q.push_back('{3'd2, 2});
    exp_q.push_back('{3'd3, 50});
    run_seq("timeout", 3'b101, 3'b000, 1'b0, 3'd7, 4);
  endtask

  task automatic test_error_restart();
    exp_q.push_back('{3'd1, 3});
    exp_q.push_back('{3'd2, 2});
    exp_q.push_back('{3'd3, 6});
    exp_q.push_back('{3'd4, 2});
    exp_q.push_back('{3'd5, 4});
    run_seq("restart", 3'b111, 3'b000, 1'b0, 3'd6, 2);
  endtask

  task automatic test_reset_mid_m1();
    logic [43:0] got;
    exp_q.push_back('{3'd1, 2});
    exp_q.push_back('{3'd2, 2});
    exp_q.push_back('{3'd3, 3});
    exp_q.push_back('{3'd4, 2});
    exp_q.push_back('{3'd5, 6});
    run_seq("pre_reset", 3'b011, 3'b000, 1'b0, 3'd5, 0);
    bus.uart_write_en_n = 1'b0; bus.m2_write_en_n = 1'b0; bus.m1_write_en_n = 1'b0;
    rst_n = 1'b0;
    #1;
    got = all_out_main();
    total++;
    if (got !== IDLE_OUT) $display("FAIL reset_mid_m1_immediate: got %h expected %h", got, IDLE_OUT);
    else passed++;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = all_out_main();
      total++;
      if (got !== IDLE_OUT) $display("FAIL reset_mid_m1_hold %0d: got %h expected %h", i, got, IDLE_OUT);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_skip_load();
    test_full_run();
    test_stale_finish();
    test_timeout();
    test_error_restart();
    test_reset_mid_m1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
